// File: rtl/custom_ip_ctrl_pkg.sv
// Shared types and sizing for the custom IP control arbiter.
//   state_e   : transaction FSM states
//   idx_width : index width helper (never narrower than one bit)
//   CH_W      : channel index width for the default channel count
//   TMO_W     : timeout counter width for the default timeout
package custom_ip_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned NUM_CH_DEF      = 3;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CH_W  = idx_width(NUM_CH_DEF);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC_DEF + 1);

endpackage

// File: rtl/custom_ip_rr_arb.sv
// Round-robin requester selection.
//   valid_i : pending request per requester
//   ptr_i   : highest-priority requester index
//   grant_o : one-hot grant, first valid requester at or after ptr_i
//   idx_o   : binary index of grant_o
//   any_o   : at least one requester valid
module custom_ip_rr_arb
  import custom_ip_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        idx_o      = IDX_W'(j);
        grant_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/custom_ip_ctrl_arbiter.sv
// Shares a NUM_CH-channel custom IP register interface between NUM_REQ
// requesters with round-robin arbitration and one transaction in flight.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_*          : per-requester valid/ready handshake with we, channel, wdata
//   rsp_*          : one-cycle response pulse to the owner, rdata and error flag
//   reg2ip_data_o  : per-channel write data (holds last written value)
//   reg2ip_en_o    : one-hot single-cycle write strobe
//   done_i         : per-channel write done (level, may be sticky)
//   ip2reg_data_i  : per-channel readback data
//   ip2reg_en_i    : per-channel readback valid (level)
module custom_ip_ctrl_arbiter
  import custom_ip_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter  int unsigned NUM_CH      = NUM_CH_DEF,
  parameter  int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int unsigned CH_BITS     = idx_width(NUM_CH),
  localparam int unsigned REQ_BITS    = idx_width(NUM_REQ),
  localparam int unsigned CNT_BITS    = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ-1:0]         req_we_i,
  input  logic [NUM_REQ*CH_BITS-1:0] req_ch_i,
  input  logic [NUM_REQ-1:0]         req_wdata_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic                       rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic [NUM_CH-1:0]          reg2ip_data_o,
  output logic [NUM_CH-1:0]          reg2ip_en_o,
  input  logic [NUM_CH-1:0]          done_i,
  input  logic [NUM_CH-1:0]          ip2reg_data_i,
  input  logic [NUM_CH-1:0]          ip2reg_en_i
);

  state_e              state_q, state_d;
  logic [REQ_BITS-1:0] ptr_q;
  logic [REQ_BITS-1:0] id_q;
  logic                we_q;
  logic [CH_BITS-1:0]  ch_q;
  logic                err_q;
  logic                rdata_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [NUM_CH-1:0]   data_q;

  logic [NUM_REQ-1:0]  grant;
  logic [REQ_BITS-1:0] grant_idx;
  logic                grant_any;
  logic [CH_BITS-1:0]  sel_ch;
  logic                sel_ch_ok;
  logic                sel_we;
  logic                sel_wdata;
  logic                tgt_done;
  logic                tmo_hit;
  logic [REQ_BITS-1:0] ptr_next;

  custom_ip_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arb (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (grant_idx),
    .any_o  (grant_any)
  );

  assign sel_ch    = req_ch_i[32'(grant_idx)*CH_BITS +: CH_BITS];
  assign sel_ch_ok = 32'(sel_ch) < NUM_CH;
  assign sel_we    = req_we_i[grant_idx];
  assign sel_wdata = req_wdata_i[grant_idx];

  // Writes complete on done, reads on readback valid; the other
  // signal on the target channel is ignored.
  assign tgt_done = we_q ? done_i[ch_q] : ip2reg_en_i[ch_q];
  // Counter value 1 means this is the last permitted WAIT cycle.
  assign tmo_hit  = (cnt_q == CNT_BITS'(1));
  assign ptr_next = (32'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;

  assign reg2ip_data_o = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    reg2ip_en_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = 1'b0;
    rsp_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = grant;
        if (grant_any) state_d = sel_ch_ok ? ISSUE : RESP;
      end
      ISSUE: begin
        if (we_q) reg2ip_en_o[ch_q] = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (tgt_done || tmo_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o[id_q] = 1'b1;
        rsp_rdata_o       = rdata_q;
        rsp_err_o         = err_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write data is committed at handshake so it is already stable on
  // reg2ip_data_o during the strobe cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      ch_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            id_q    <= grant_idx;
            we_q    <= sel_we;
            ch_q    <= sel_ch;
            err_q   <= !sel_ch_ok;
            rdata_q <= 1'b0;
            if (sel_we && sel_ch_ok) data_q[sel_ch] <= sel_wdata;
          end
        end
        ISSUE: begin
          cnt_q <= CNT_BITS'(TIMEOUT_CYC);
        end
        WAIT: begin
          if (tgt_done) begin
            if (!we_q) rdata_q <= ip2reg_data_i[ch_q];
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (tmo_hit) err_q <= 1'b1;
          end
        end
        RESP: begin
          ptr_q <= ptr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_ip_ctrl_arbiter.sv
module tb_custom_ip_ctrl_arbiter;

  localparam int NR  = 4;
  localparam int NC  = 3;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_ready, req_we, req_wdata, rsp_valid;
  logic [7:0] req_ch;
  logic       rsp_rdata, rsp_err;
  logic [2:0] reg2ip_data, reg2ip_en, done, ip2reg_data, ip2reg_en;

  int errors = 0;
  int checks = 0;

  // Reference state: round-robin pointer and last written data per channel.
  int         ptr_m = 0;
  logic [2:0] dm    = '0;

  always #5 clk = ~clk;

  custom_ip_ctrl_arbiter #(
    .NUM_REQ    (NR),
    .NUM_CH     (NC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_ch_i     (req_ch),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .reg2ip_data_o(reg2ip_data),
    .reg2ip_en_o  (reg2ip_en),
    .done_i       (done),
    .ip2reg_data_i(ip2reg_data),
    .ip2reg_en_i  (ip2reg_en)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_grant(input logic [3:0] mask);
    for (int i = 0; i < NR; i++) begin
      if (mask[(ptr_m + i) % NR]) return (ptr_m + i) % NR;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    ptr_m = 0;
    dm = '0;
  endtask

  // One complete transaction. Completion level on the target channel rises
  // at cycle k after the handshake cycle (cycle 0) and stays high.
  task automatic do_txn(input logic [3:0] mask, input logic [3:0] we,
                        input logic [7:0] ch, input logic [3:0] wd,
                        input int k, input logic rd, output int g_out);
    int g, gch, resp_n, cdone;
    logic we_g, wd_g, exp_err, exp_rd;
    logic [3:0] exp_rdy, exp_rsp;
    logic [2:0] exp_en;
    logic [1:0] chs;
    g = model_grant(mask);
    g_out = g;
    req_valid = mask;
    req_we = we;
    req_ch = ch;
    req_wdata = wd;
    #1;
    exp_rdy = 4'b0001 << g;
    checks++;
    if (req_ready !== exp_rdy || rsp_valid !== 4'b0 || reg2ip_en !== 3'b0) begin
      errors++;
      $display("FAIL handshake: ready=%b rsp=%b en=%b, required ready=%b rsp=0000 en=000",
               req_ready, rsp_valid, reg2ip_en, exp_rdy);
    end
    chs = ch[g*2 +: 2];
    gch = int'(chs);
    we_g = we[g];
    wd_g = wd[g];
    if (gch >= NC) begin
      resp_n = 1; exp_err = 1'b1; exp_rd = 1'b0;
    end else begin
      cdone = (k < 2) ? 2 : k;
      if (cdone - 2 < TMO) begin
        resp_n = cdone + 1; exp_err = 1'b0; exp_rd = we_g ? 1'b0 : rd;
      end else begin
        resp_n = TMO + 2; exp_err = 1'b1; exp_rd = 1'b0;
      end
      if (we_g) dm[gch] = wd_g;
    end
    tick();
    req_valid = mask & ~(4'b0001 << g);
    for (int n = 1; n <= resp_n; n++) begin
      for (int c = 0; c < NC; c++) begin
        done[c]        = (c == gch && we_g)  ? (n >= k) : 1'($urandom());
        ip2reg_en[c]   = (c == gch && !we_g) ? (n >= k) : 1'($urandom());
        ip2reg_data[c] = (c == gch) ? rd : 1'($urandom());
      end
      #1;
      exp_rsp = (n == resp_n) ? (4'b0001 << g) : 4'b0;
      exp_en  = (n == 1 && we_g && gch < NC) ? (3'b001 << gch) : 3'b0;
      checks++;
      if (req_ready !== 4'b0 || rsp_valid !== exp_rsp || reg2ip_en !== exp_en ||
          reg2ip_data !== dm) begin
        errors++;
        $display("FAIL txn cycle %0d: ready=%b rsp=%b en=%b data=%b, required ready=0000 rsp=%b en=%b data=%b",
                 n, req_ready, rsp_valid, reg2ip_en, reg2ip_data, exp_rsp, exp_en, dm);
      end
      if (n == resp_n) begin
        checks++;
        if (rsp_err !== exp_err || rsp_rdata !== exp_rd) begin
          errors++;
          $display("FAIL rsp fields: err=%b rdata=%b, required err=%b rdata=%b",
                   rsp_err, rsp_rdata, exp_err, exp_rd);
        end
      end
      tick();
    end
    ptr_m = (g + 1) % NR;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, reg2ip_data, reg2ip_en} !== '0) begin
      errors++;
      $display("FAIL reset outputs: ready=%b rsp=%b rd=%b err=%b data=%b en=%b, required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, reg2ip_data, reg2ip_en);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset pointer: ready=%b, required 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_write();
    int g;
    do_txn(4'b0001, 4'b0001, 8'b00_00_00_01, 4'b0001, 3, 1'b0, g);
  endtask

  task automatic test_read();
    int g;
    do_txn(4'b0100, 4'b0000, 8'b00_00_00_00, 4'b0000, 1, 1'b1, g);
  endtask

  task automatic test_badch();
    int g;
    do_txn(4'b0010, 4'b0010, 8'b00_00_11_00, 4'b0010, 1, 1'b0, g);
    do_txn(4'b1000, 4'b0000, 8'b11_00_00_00, 4'b0000, 1, 1'b1, g);
  endtask

  task automatic test_timeout();
    int g;
    // never completes, then a back-to-back request right after the error
    do_txn(4'b0001, 4'b0001, 8'b00_00_00_10, 4'b0001, 1000, 1'b0, g);
    do_txn(4'b0010, 4'b0010, 8'b00_00_10_00, 4'b0000, 17, 1'b0, g);
    do_txn(4'b0100, 4'b0100, 8'b00_10_00_00, 4'b0100, 18, 1'b0, g);
    do_txn(4'b1000, 4'b0000, 8'b01_00_00_00, 4'b0000, 1000, 1'b1, g);
    do_txn(4'b0001, 4'b0000, 8'b00_00_00_01, 4'b0000, 17, 1'b1, g);
  endtask

  task automatic test_fairness();
    int g;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 4'b1111, 8'b10_01_00_10, 4'($urandom()), 1, 1'b0, g);
      checks++;
      if (g !== exp_seq[i]) begin
        errors++;
        $display("FAIL fairness order %0d: granted %0d, required %0d", i, g, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001;
    req_we = 4'b0001;
    req_ch = 8'b0;
    req_wdata = 4'b0001;
    done = '0;
    ip2reg_en = '0;
    tick();
    req_valid = '0;
    for (int n = 1; n < 5; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, reg2ip_data, reg2ip_en} !== '0) begin
      errors++;
      $display("FAIL mid reset outputs: ready=%b rsp=%b rd=%b err=%b data=%b en=%b, required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, reg2ip_data, reg2ip_en);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (rsp_valid !== 4'b0 || reg2ip_en !== 3'b0) begin
        errors++;
        $display("FAIL mid reset quiet %0d: rsp=%b en=%b, required 0", n, rsp_valid, reg2ip_en);
      end
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid reset pointer: ready=%b, required 0001", req_ready);
    end
    req_valid = '0;
    ptr_m = 0;
    dm = '0;
    #1;
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 40; i++) begin
      do_txn(4'($urandom_range(1, 15)), 4'($urandom()), 8'($urandom()), 4'($urandom()),
             int'($urandom_range(1, 20)), 1'($urandom()), g);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_ch = '0;
    req_wdata = '0;
    done = '0;
    ip2reg_data = '0;
    ip2reg_en = '0;
    tick();
    test_reset();
    test_write();
    test_read();
    test_badch();
    test_timeout();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
